// File: rtl/robber_decoder.sv
// Streaming Robber Language decoder: collapses consonant-o-consonant triplets
// into one character, passes vowels through, and counts malformed triplets.
module robber_decoder #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter logic [7:0]  O_CHAR    = 8'h6F
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [7:0]           data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [7:0]           data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [CNT_WIDTH-1:0] char_count,
  output logic                 in_triplet
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_C  = 2'd1,
    WAIT_O  = 2'd2,
    WAIT_C2 = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [7:0]           r_hold;
  logic [7:0]           w_hold_nxt;
  logic [7:0]           r_dout;
  logic                 r_dout_valid;
  logic                 r_error;
  logic [CNT_WIDTH-1:0] r_err_cnt;
  logic [CNT_WIDTH-1:0] r_char_cnt;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_fresh;
  logic w_emit;
  logic w_malformed;
  logic w_is_vowel;

  function automatic logic is_vowel(input logic [7:0] c);
    case (c)
      8'h61, 8'h41, 8'h65, 8'h45, 8'h69, 8'h49,
      8'h6F, 8'h4F, 8'h75, 8'h55, 8'h79, 8'h59: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

  assign data_in_ready = (r_state != IDLE) && !init &&
                         (!r_dout_valid || data_out_ready);
  assign w_in_xfer     = data_in_valid && data_in_ready;
  assign w_out_xfer    = r_dout_valid && data_out_ready;
  assign w_is_vowel    = is_vowel(data_in);

  // A broken triplet is reported, then the offending byte is decoded as if it
  // had arrived in WAIT_C; w_fresh funnels all three cases into one path.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_fresh     = 1'b0;
    w_emit      = 1'b0;
    w_malformed = 1'b0;
    case (r_state)
      IDLE: ;
      WAIT_C: w_fresh = w_in_xfer;
      WAIT_O: begin
        if (w_in_xfer) begin
          if (data_in == O_CHAR) begin
            w_state_nxt = WAIT_C2;
          end else begin
            w_malformed = 1'b1;
            w_fresh     = 1'b1;
          end
        end
      end
      WAIT_C2: begin
        if (w_in_xfer) begin
          if (data_in == r_hold) begin
            w_state_nxt = WAIT_C;
          end else begin
            w_malformed = 1'b1;
            w_fresh     = 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_fresh) begin
      w_emit = 1'b1;
      if (w_is_vowel) begin
        w_state_nxt = WAIT_C;
      end else begin
        w_state_nxt = WAIT_O;
        w_hold_nxt  = data_in;
      end
    end
    if (init) begin
      w_state_nxt = WAIT_C;
      w_hold_nxt  = '0;
      w_emit      = 1'b0;
      w_malformed = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_error      <= 1'b0;
      r_err_cnt    <= '0;
      r_char_cnt   <= '0;
    end else if (init) begin
      r_dout_valid <= 1'b0;
      r_error      <= 1'b0;
      r_err_cnt    <= '0;
      r_char_cnt   <= '0;
    end else begin
      r_error <= w_malformed;
      if (w_malformed && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
      end
      if (w_emit) begin
        r_dout       <= data_in;
        r_dout_valid <= 1'b1;
        if (r_char_cnt != '1) begin
          r_char_cnt <= r_char_cnt + CNT_WIDTH'(1);
        end
      end else if (w_out_xfer) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign data_out       = r_dout;
  assign data_out_valid = r_dout_valid;
  assign error          = r_error;
  assign error_count    = r_err_cnt;
  assign char_count     = r_char_cnt;
  assign in_triplet     = (r_state == WAIT_O) || (r_state == WAIT_C2);

endmodule

// File: tb/tb_robber_decoder.sv
// Directed and random checks of robber_decoder against a stream-level model
// of the Robber Language rules, with 4-bit counters to reach saturation.
module tb_robber_decoder;

  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          dvld = 1'b0;
  logic          ordy = 1'b1;
  logic          data_in_ready;
  logic [7:0]    data_out;
  logic          data_out_valid;
  logic          error;
  logic [CW-1:0] error_count;
  logic [CW-1:0] char_count;
  logic          in_triplet;

  robber_decoder #(.CNT_WIDTH(CW), .O_CHAR(8'h6F)) dut (
    .clk(clk), .reset(reset), .init(init),
    .data_in(din), .data_in_valid(dvld), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(ordy), .error(error), .error_count(error_count),
    .char_count(char_count), .in_triplet(in_triplet)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int err_seen = 0;
  logic [7:0] q_obs[$];

  // Model: decoder started?, pending consonant, whether its 'o' has arrived
  bit          m_active = 0;
  bit          m_pend = 0;
  logic [7:0]  m_pc = 8'h00;
  bit          m_seen_o = 0;
  logic [7:0]  m_dout = 8'h00;
  bit          m_ov = 0;
  bit          m_err = 0;
  int unsigned m_ecnt = 0;
  int unsigned m_ccnt = 0;

  function automatic bit is_vowel(input logic [7:0] c);
    string v;
    v = "aAeEiIoOuUyY";
    for (int i = 0; i < v.len(); i++) if (v[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic vld, input logic [7:0] d, input logic ordy_i,
                      input logic init_i, input logic rst_i);
    bit rdy, xfer, oxfer, emit;
    reset = rst_i; init = init_i; dvld = vld; din = d; ordy = ordy_i;
    #1;
    rdy = m_active && !init_i && (!m_ov || ordy_i);
    check("in_ready", {31'b0, data_in_ready}, {31'b0, rdy});
    if (data_out_valid && ordy_i) q_obs.push_back(data_out);
    xfer  = vld && rdy;
    oxfer = m_ov && ordy_i;
    emit  = 0;
    @(posedge clk); #1;
    if (rst_i) begin
      m_active = 0; m_pend = 0; m_pc = 8'h00; m_seen_o = 0;
      m_dout = 8'h00; m_ov = 0; m_err = 0; m_ecnt = 0; m_ccnt = 0;
    end else if (init_i) begin
      m_active = 1; m_pend = 0; m_seen_o = 0; m_ov = 0; m_err = 0;
      m_ecnt = 0; m_ccnt = 0;
    end else begin
      m_err = 0;
      if (xfer) begin
        if (m_pend && !m_seen_o && d == 8'h6F) m_seen_o = 1;
        else if (m_pend && m_seen_o && d == m_pc) m_pend = 0;
        else begin
          if (m_pend) m_err = 1;
          emit = 1;
          m_pend = !is_vowel(d); m_pc = d; m_seen_o = 0;
        end
      end
      if (m_err && m_ecnt < CMAX) m_ecnt++;
      if (emit) begin
        m_dout = d; m_ov = 1;
        if (m_ccnt < CMAX) m_ccnt++;
      end else if (oxfer) m_ov = 0;
    end
    check("out_valid", {31'b0, data_out_valid}, {31'b0, m_ov});
    check("data_out", {24'b0, data_out}, {24'b0, m_dout});
    check("error", {31'b0, error}, {31'b0, m_err});
    check("error_count", {28'b0, error_count}, m_ecnt);
    check("char_count", {28'b0, char_count}, m_ccnt);
    check("in_triplet", {31'b0, in_triplet}, {31'b0, m_pend});
    if (error) err_seen++;
    @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_stream(input string tag, input string exp);
    check({tag, " len"}, q_obs.size(), exp.len());
    for (int i = 0; i < exp.len() && i < q_obs.size(); i++)
      check({tag, " char"}, {24'b0, q_obs[i]}, {24'b0, exp[i]});
  endtask

  task automatic do_init();
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    q_obs.delete();
    err_seen = 0;
  endtask

  initial begin
    logic [7:0] last_cons;
    string      alpha;
    logic [7:0] d;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // reset state, decoder held in IDLE
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h61, 1'b1, 1'b0, 1'b0);
    check("reset ready", {31'b0, data_in_ready}, 32'd0);

    // T1
    do_init();
    send_str("sosomomarore");
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_stream("T1 stream", "somare");
    check("T1 char_count", {28'b0, char_count}, 32'd6);
    check("T1 error_count", {28'b0, error_count}, 32'd0);

    // T2
    do_init();
    send_str("hxa");
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_stream("T2 stream", "hxa");
    check("T2 pulses", err_seen, 32'd2);
    check("T2 error_count", {28'b0, error_count}, 32'd2);

    // T3
    do_init();
    step(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
    check("T3 held ready", {31'b0, data_in_ready}, 32'd0);
    check("T3 held data", {24'b0, data_out}, 32'h61);
    step(1'b1, 8'h62, 1'b1, 1'b0, 1'b0);
    check("T3 first out", q_obs.size(), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("T3 no gap", q_obs.size(), 32'd2);
    check_stream("T3 stream", "ab");

    // T4
    do_init();
    send_str("ho");
    check("T4 mid triplet", {31'b0, in_triplet}, 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    check("T4 aborted", {31'b0, in_triplet}, 32'd0);
    check("T4 no error", {31'b0, error}, 32'd0);
    send_str("h");
    check("T4 data_out", {24'b0, data_out}, 32'h68);
    check("T4 in_triplet", {31'b0, in_triplet}, 32'd1);
    check("T4 error_count", {28'b0, error_count}, 32'd0);

    // T5
    do_init();
    send_str("to");
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    check("T5 valid", {31'b0, data_out_valid}, 32'd0);
    check("T5 in_triplet", {31'b0, in_triplet}, 32'd0);
    repeat (3) step(1'b1, 8'h74, 1'b1, 1'b0, 1'b0);
    check("T5 ready", {31'b0, data_in_ready}, 32'd0);
    check("T5 char_count", {28'b0, char_count}, 32'd0);

    // T6: 2^CW+3 malformed triplets
    do_init();
    for (int i = 0; i < (1 << CW) + 3; i++) send_str("ba");
    check("T6 error_count", {28'b0, error_count}, CMAX);
    check("T6 char_count", {28'b0, char_count}, CMAX);

    // random traffic with occasional init and reset
    do_init();
    alpha = "bbssoooaOe xt";
    last_cons = 8'h62;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) d = last_cons;
      else d = alpha[$urandom_range(0, alpha.len() - 1)];
      if (!is_vowel(d)) last_cons = d;
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0,
           $urandom_range(0, 149) == 0, $urandom_range(0, 599) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
